block_raster_buf: RTL and testbench

BLOCK_RASTER_BUF -- requirements
Module: block_raster_buf

---
 rtl/block_raster_buf_pkg.sv | 23 ++
 rtl/blk_wr_addr_gen.sv | 51 +++++
 rtl/block_raster_buf.sv | 219 +++++++++++++++++++++
 tb/tb_block_raster_buf.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_raster_buf_pkg.sv
// Shared types and helpers for the block-to-raster stripe buffer.
// Holds the default pixel width, the bank address width function and the FSM state encodings.
package block_raster_buf_pkg;

  localparam int DATA_W = 24;

  // One bank stores an 8-line stripe: 3 row bits on top of the hcnt bits.
  function automatic int bank_aw(input int width);
    return $clog2(width) + 3;
  endfunction

  typedef enum logic {
    WR_BANK0 = 1'b0,
    WR_BANK1 = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_BANK0 = 2'd1,
    RD_BANK1 = 2'd2
  } rd_state_t;

endpackage

// File: rtl/blk_wr_addr_gen.sv
// Write-side address generator: walks col, then row, then mcu across one 8-line stripe.
// stripe_end flags the final beat of the stripe (row 7, col 7, last mcu).
module blk_wr_addr_gen #(
  parameter int WIDTH = 1280
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv,
  output logic [2:0]                row,
  output logic [2:0]                col,
  output logic [$clog2(WIDTH)-4:0]  mcu,
  output logic                      stripe_end
);

  localparam int MCU_W = $clog2(WIDTH) - 3;

  logic [2:0]       row_r;
  logic [2:0]       col_r;
  logic [MCU_W-1:0] mcu_r;

  assign row        = row_r;
  assign col        = col_r;
  assign mcu        = mcu_r;
  assign stripe_end = (row_r == 3'd7) && (col_r == 3'd7) && (mcu_r == MCU_W'(WIDTH/8 - 1));

  // Advance the block-order counters on each accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r <= 3'd0;
      col_r <= 3'd0;
      mcu_r <= '0;
    end else if (adv) begin
      col_r <= col_r + 3'd1;
      if (col_r == 3'd7) begin
        row_r <= row_r + 3'd1;
        if (row_r == 3'd7) begin
          mcu_r <= stripe_end ? '0 : mcu_r + MCU_W'(1);
        end else begin
          mcu_r <= mcu_r;
        end
      end else begin
        row_r <= row_r;
      end
    end else begin
      row_r <= row_r;
      col_r <= col_r;
      mcu_r <= mcu_r;
    end
  end

endmodule

// File: rtl/block_raster_buf.sv
// Ping-pong stripe buffer: accepts 8x8 blocks, emits raster-order pixels with sof/eol/eof.
// Two RAM banks alternate between write (block order) and read (raster order).
module block_raster_buf #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int DATA_W = block_raster_buf_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof
);
  import block_raster_buf_pkg::*;

  localparam int AW    = bank_aw(WIDTH);
  localparam int DEPTH = 1 << AW;
  localparam int HC_W  = $clog2(WIDTH);
  localparam int MCU_W = HC_W - 3;
  localparam int ST_W  = (HEIGHT/8 > 1) ? $clog2(HEIGHT/8) : 1;

  logic [2:0]        wr_row_s;
  logic [2:0]        wr_col_s;
  logic [MCU_W-1:0]  wr_mcu_s;
  logic              stripe_end_s;
  logic              wr_fire_s;
  logic [AW-1:0]     wr_addr_s;
  wr_state_t         wr_state_r;
  wr_state_t         wr_next_s;
  logic [1:0]        full_r;
  logic [1:0]        full_set_s;
  logic [1:0]        full_clr_s;
  logic [1:0]        full_next_s;

  rd_state_t         rd_state_r;
  logic              rd_exp_r;
  logic [2:0]        rd_row_r;
  logic [HC_W-1:0]   rd_hcnt_r;
  logic              rd_done_r;
  logic [ST_W-1:0]   stripe_r;
  logic              rd_bank_s;
  logic              rd_full_s;
  logic              adv_s;
  logic              issue_s;
  logic [AW-1:0]     rd_addr_s;
  logic              eol_s;
  logic              last_row_s;
  logic              sof_s;
  logic              eof_s;
  logic              last_xfer_s;

  logic              s1_valid_r;
  logic              s1_bank_r;
  logic              s1_sof_r;
  logic              s1_eol_r;
  logic              s1_eof_r;
  logic              s1_last_r;
  logic              out_last_r;

  logic [DATA_W-1:0] mem0_r [DEPTH];
  logic [DATA_W-1:0] mem1_r [DEPTH];
  logic [DATA_W-1:0] q0_r;
  logic [DATA_W-1:0] q1_r;

  blk_wr_addr_gen #(.WIDTH(WIDTH)) u_wr_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .adv        (wr_fire_s),
    .row        (wr_row_s),
    .col        (wr_col_s),
    .mcu        (wr_mcu_s),
    .stripe_end (stripe_end_s)
  );

  assign wr_fire_s = in_valid && in_ready;
  assign wr_addr_s = {wr_row_s, wr_mcu_s, wr_col_s};

  // Write bank switch and full-flag set/clear; both sides may update in one cycle
  always_comb begin
    if (wr_fire_s && stripe_end_s) begin
      wr_next_s  = (wr_state_r == WR_BANK0) ? WR_BANK1 : WR_BANK0;
      full_set_s = (wr_state_r == WR_BANK1) ? 2'b10 : 2'b01;
    end else begin
      wr_next_s  = wr_state_r;
      full_set_s = 2'b00;
    end
    if (last_xfer_s) begin
      full_clr_s = (rd_state_r == RD_BANK1) ? 2'b10 : 2'b01;
    end else begin
      full_clr_s = 2'b00;
    end
    full_next_s = (full_r | full_set_s) & ~full_clr_s;
  end

  // Write FSM, full flags and registered in_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= WR_BANK0;
      full_r     <= 2'b00;
      in_ready   <= 1'b1;
    end else begin
      wr_state_r <= wr_next_s;
      full_r     <= full_next_s;
      in_ready   <= (wr_next_s == WR_BANK1) ? ~full_next_s[1] : ~full_next_s[0];
    end
  end

  // Read bank is the expected bank while idle so the first read issues without a wait cycle
  always_comb begin
    case (rd_state_r)
      RD_BANK0: rd_bank_s = 1'b0;
      RD_BANK1: rd_bank_s = 1'b1;
      default:  rd_bank_s = rd_exp_r;
    endcase
  end

  assign rd_full_s   = rd_bank_s ? full_r[1] : full_r[0];
  assign adv_s       = !out_valid || out_ready;
  assign issue_s     = adv_s && ((rd_state_r == RD_IDLE) ? rd_full_s : !rd_done_r);
  assign rd_addr_s   = {rd_row_r, rd_hcnt_r};
  assign eol_s       = (rd_hcnt_r == HC_W'(WIDTH - 1));
  assign last_row_s  = (rd_row_r == 3'd7);
  assign sof_s       = (stripe_r == '0) && (rd_row_r == 3'd0) && (rd_hcnt_r == '0);
  assign eof_s       = eol_s && last_row_s && (stripe_r == ST_W'(HEIGHT/8 - 1));
  assign last_xfer_s = out_valid && out_ready && out_last_r;

  // Bank 0 storage with registered read port
  always_ff @(posedge clk) begin
    if (wr_fire_s && (wr_state_r == WR_BANK0)) begin
      mem0_r[wr_addr_s] <= in_data;
    end
    if (issue_s && !rd_bank_s) begin
      q0_r <= mem0_r[rd_addr_s];
    end
  end

  // Bank 1 storage with registered read port
  always_ff @(posedge clk) begin
    if (wr_fire_s && (wr_state_r == WR_BANK1)) begin
      mem1_r[wr_addr_s] <= in_data;
    end
    if (issue_s && rd_bank_s) begin
      q1_r <= mem1_r[rd_addr_s];
    end
  end

  // Read FSM, raster counters and the RAM/output pipeline; everything holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r <= RD_IDLE;
      rd_exp_r   <= 1'b0;
      rd_row_r   <= 3'd0;
      rd_hcnt_r  <= '0;
      rd_done_r  <= 1'b0;
      stripe_r   <= '0;
      s1_valid_r <= 1'b0;
      s1_bank_r  <= 1'b0;
      s1_sof_r   <= 1'b0;
      s1_eol_r   <= 1'b0;
      s1_eof_r   <= 1'b0;
      s1_last_r  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      out_last_r <= 1'b0;
    end else begin
      if (issue_s) begin
        if (eol_s) begin
          rd_hcnt_r <= '0;
          rd_row_r  <= rd_row_r + 3'd1;
          if (last_row_s) begin
            rd_done_r <= 1'b1;
          end
        end else begin
          rd_hcnt_r <= rd_hcnt_r + HC_W'(1);
        end
      end
      case (rd_state_r)
        RD_IDLE: begin
          if (issue_s) begin
            rd_state_r <= rd_exp_r ? RD_BANK1 : RD_BANK0;
          end
        end
        RD_BANK0, RD_BANK1: begin
          if (last_xfer_s) begin
            rd_state_r <= RD_IDLE;
            rd_exp_r   <= ~rd_exp_r;
            rd_done_r  <= 1'b0;
            stripe_r   <= (stripe_r == ST_W'(HEIGHT/8 - 1)) ? '0 : stripe_r + ST_W'(1);
          end
        end
        default: rd_state_r <= RD_IDLE;
      endcase
      if (adv_s) begin
        s1_valid_r <= issue_s;
        s1_bank_r  <= rd_bank_s;
        s1_sof_r   <= sof_s;
        s1_eol_r   <= eol_s;
        s1_eof_r   <= eof_s;
        s1_last_r  <= eol_s && last_row_s;
        out_valid  <= s1_valid_r;
        out_data   <= s1_bank_r ? q1_r : q0_r;
        out_sof    <= s1_valid_r && s1_sof_r;
        out_eol    <= s1_valid_r && s1_eol_r;
        out_eof    <= s1_valid_r && s1_eof_r;
        out_last_r <= s1_valid_r && s1_last_r;
      end
    end
  end

endmodule

// File: tb/tb_block_raster_buf.sv
// Randomized bench for block_raster_buf (WIDTH=16, HEIGHT=16) against a stripe-level raster model.
module tb_block_raster_buf;

  localparam int W   = 16;
  localparam int H   = 16;
  localparam int DW  = 24;
  localparam int NS  = H / 8;
  localparam int SPX = 8 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          out_sof, out_eol, out_eof;

  int n_checks = 0;
  int n_errors = 0;

  block_raster_buf #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: each completed stripe expands into raster order with frame flags.
  logic [DW-1:0]    cur_img [8][W];
  logic [DW+2:0]    exp_q[$];
  int               m_stripe = 0;

  task automatic push_stripe();
    for (int r = 0; r < 8; r++) begin
      for (int h = 0; h < W; h++) begin
        logic sof, eol, eof;
        sof = (m_stripe == 0) && (r == 0) && (h == 0);
        eol = (h == W - 1);
        eof = eol && (r == 7) && (m_stripe == NS - 1);
        exp_q.push_back({sof, eol, eof, cur_img[r][h]});
      end
    end
    m_stripe = (m_stripe + 1) % NS;
  endtask

  // Output monitor: compares every transfer with the model and checks stall stability.
  int            out_cnt = 0, sof_cnt = 0, eol_cnt = 0, eof_cnt = 0, first_eof_idx = -1;
  bit            stall_p = 1'b0;
  logic [DW+2:0] stall_v;

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) check("stall_hold", {out_valid, out_sof, out_eol, out_eof, out_data}, {1'b1, stall_v});
      if (out_valid && out_ready) begin
        check("out_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("out_pixel", {out_sof, out_eol, out_eof, out_data}, exp_q.pop_front());
        if (out_sof) sof_cnt++;
        if (out_eol) eol_cnt++;
        if (out_eof) begin
          eof_cnt++;
          if (first_eof_idx < 0) first_eof_idx = out_cnt;
        end
        out_cnt++;
      end
      stall_p = out_valid && !out_ready;
      stall_v = {out_sof, out_eol, out_eof, out_data};
    end
  end

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  bit abort   = 1'b0;
  int gap_pct = 0;

  task automatic send_beat(input logic [DW-1:0] pix);
    bit acc;
    int budget;
    while (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = pix;
    acc      = 1'b0;
    budget   = 0;
    while (!acc && !abort) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      budget++;
      if (!acc && budget > 3000) begin
        check("in_ready_timeout", in_ready, 1'b1);
        abort = 1'b1;
      end
    end
  endtask

  // kind 0: pixel = {row, hcnt}; kind 1: random pixels. Block order: mcu, row, col.
  task automatic send_stripe(input int kind, input int nbeats);
    for (int r = 0; r < 8; r++)
      for (int h = 0; h < W; h++)
        cur_img[r][h] = (kind == 0) ? DW'((r << 8) | h) : DW'($urandom);
    for (int i = 0; i < nbeats; i++)
      send_beat(cur_img[(i / 8) % 8][(i / 64) * 8 + (i % 8)]);
    in_valid = 1'b0;
    if (nbeats >= SPX) push_stripe();
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while (exp_q.size() != 0 && b < 5000) begin
      @(posedge clk);
      b++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int neol, b, base_cnt, base_eol;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_flags", {out_sof, out_eol, out_eof}, 3'b000);
    @(posedge clk); #1;

    // Single patterned stripe, then latency from bank full to out_valid
    send_stripe(0, SPX);
    @(negedge clk); check("lat_c0", out_valid, 1'b0);
    @(negedge clk); check("lat_c1", out_valid, 1'b0);
    @(negedge clk); check("lat_c2", out_valid, 1'b1);
    @(posedge clk); #1;
    drain("stripe0");
    check("stripe0_count", out_cnt, SPX);
    check("stripe0_eol", eol_cnt, 8);
    send_stripe(1, SPX);
    drain("frame0");
    check("frame0_count", out_cnt, 2 * SPX);
    check("frame0_sof", sof_cnt, 1);
    check("frame0_eof", eof_cnt, 1);
    check("frame0_eof_idx", first_eof_idx, 2 * SPX - 1);
    send_stripe(0, SPX);
    drain("frame1");
    check("sof_wrap", sof_cnt, 2);

    // Output blocked while two stripes arrive
    rdy_mode = 1;
    send_stripe(1, SPX);
    send_stripe(1, SPX);
    @(negedge clk); check("both_full_in_ready", in_ready, 1'b0);
    repeat (10) @(negedge clk);
    check("stalled_in_ready", in_ready, 1'b0);
    check("stalled_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    rdy_mode = 0;
    neol = 0; b = 0;
    while (neol < 8 && b < 1000) begin
      @(negedge clk);
      b++;
      if (out_valid && out_ready && out_eol) begin
        neol++;
        if (neol == 8) check("in_ready_at_last", in_ready, 1'b0);
      end
    end
    check("last_seen", neol, 8);
    @(negedge clk); check("in_ready_return", in_ready, 1'b1);
    @(posedge clk); #1;
    drain("backpressure");

    // Random output stalls and input gaps
    rdy_mode = 2;
    gap_pct  = 25;
    repeat (3) send_stripe(1, SPX);
    drain("random");
    gap_pct  = 0;
    rdy_mode = 0;
    @(posedge clk); #1;

    // Bank 1 stripe end coinciding with the final read transfer of bank 0
    base_eol = eol_cnt;
    send_stripe(1, SPX);
    send_stripe(1, SPX - 1);
    b = 0;
    while (!(out_valid && out_ready && out_eol && (eol_cnt - base_eol == 8)) && b < 300) begin
      @(negedge clk); #1;
      b++;
    end
    check("coincide_found", eol_cnt - base_eol, 8);
    in_valid = 1'b1;
    in_data  = cur_img[7][W-1];
    check("coincide_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    push_stripe();
    @(negedge clk); check("bank0_freed", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk); check("bank1_start", out_valid, 1'b1);
    @(posedge clk); #1;
    drain("coincide");

    // Reset in the middle of a stripe, then a clean stripe
    send_stripe(1, 40);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_stripe = 0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    base_cnt = out_cnt;
    send_stripe(0, SPX);
    drain("post_reset");
    check("post_reset_count", out_cnt - base_cnt, SPX);
    check("idle_out_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
